// File: rtl/icap_cfg_reader.sv
// ICAPE3 configuration-register reader: sync/header, one-word read, desync.
// Optional macro ICAP_RD_TIMEOUT_EN bounds the wait for icap_avail by AVAIL_TIMEOUT.
module icap_cfg_reader #(
    parameter int unsigned READ_LAT      = 3,
    parameter int unsigned AVAIL_TIMEOUT = 255
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        rd_req,
    input  logic [4:0]  rd_reg_addr,
    output logic        rd_busy,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        rd_timeout,
    input  logic        icap_avail,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    input  logic [31:0] icap_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_AVAIL = 3'd1,
        WR_HDR     = 3'd2,
        SW_RD      = 3'd3,
        READ       = 3'd4,
        SW_WR      = 3'd5,
        WR_DESYNC  = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
        $error("icap_cfg_reader: READ_LAT must be 1..15");
    end
    if (AVAIL_TIMEOUT < 1 || AVAIL_TIMEOUT > 65535) begin : g_bad_avail_timeout
        $error("icap_cfg_reader: AVAIL_TIMEOUT must be 1..65535");
    end

    // ICAP transfers each byte MSB-last, so bits are mirrored inside every byte.
    function automatic logic [31:0] bitrev_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = w[8*b+7-i];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] hdr_word(input logic [2:0] idx, input logic [4:0] addr);
        logic [31:0] w;
        case (idx)
            3'd0:    w = 32'hFFFF_FFFF;
            3'd1:    w = 32'hAA99_5566;
            3'd4:    w = 32'h2800_0001 | {14'd0, addr, 13'd0};
            3'd2, 3'd3, 3'd5, 3'd6: w = 32'h2000_0000;
            default: w = 32'hFFFF_FFFF;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] desync_word(input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = 32'h3000_8001;
            3'd1:    w = 32'h0000_000D;
            3'd2, 3'd3: w = 32'h2000_0000;
            default: w = 32'hFFFF_FFFF;
        endcase
        return w;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  lat_q, lat_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        csib_q, csib_d;
    logic        rdwrb_q, rdwrb_d;
    logic [31:0] icap_i_q, icap_i_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef ICAP_RD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(AVAIL_TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
`endif

    // Next-state logic; ICAP pins are precomputed from the next state so they register in step with it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        data_d   = data_q;
`ifdef ICAP_RD_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_reg_addr;
                    idx_d   = 3'd0;
                    lat_d   = 4'd0;
                    state_d = WAIT_AVAIL;
`ifdef ICAP_RD_TIMEOUT_EN
                    tmo_d     = 16'd0;
                    timeout_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_AVAIL: begin
                if (icap_avail) begin
                    idx_d   = 3'd0;
                    state_d = WR_HDR;
`ifdef ICAP_RD_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
`else
                end else begin
                    state_d = WAIT_AVAIL;
`endif
                end
            end
            WR_HDR: begin
                if (idx_q == 3'd6) begin
                    idx_d   = 3'd0;
                    state_d = SW_RD;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SW_RD: begin
                lat_d   = 4'd0;
                state_d = READ;
            end
            READ: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = bitrev_bytes(icap_o);
                    state_d = SW_WR;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            SW_WR: begin
                idx_d   = 3'd0;
                state_d = WR_DESYNC;
            end
            WR_DESYNC: begin
                if (idx_q == 3'd3) begin
                    idx_d   = 3'd0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            WR_HDR: begin
                csib_d   = 1'b0;
                rdwrb_d  = 1'b0;
                icap_i_d = bitrev_bytes(hdr_word(idx_d, addr_d));
            end
            WR_DESYNC: begin
                csib_d   = 1'b0;
                rdwrb_d  = 1'b0;
                icap_i_d = bitrev_bytes(desync_word(idx_d));
            end
            READ: begin
                csib_d   = 1'b0;
                rdwrb_d  = 1'b1;
                icap_i_d = 32'hFFFF_FFFF;
            end
            SW_RD: begin
                csib_d   = 1'b1;
                rdwrb_d  = 1'b1;
                icap_i_d = 32'hFFFF_FFFF;
            end
            default: begin
                csib_d   = 1'b1;
                rdwrb_d  = 1'b0;
                icap_i_d = 32'hFFFF_FFFF;
            end
        endcase
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            lat_q    <= 4'd0;
            addr_q   <= 5'd0;
            data_q   <= 32'h0000_0000;
            csib_q   <= 1'b1;
            rdwrb_q  <= 1'b0;
            icap_i_q <= 32'hFFFF_FFFF;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            csib_q   <= csib_d;
            rdwrb_q  <= rdwrb_d;
            icap_i_q <= icap_i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef ICAP_RD_TIMEOUT_EN
    // Wait-for-avail counter and sticky timeout flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tmo_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
    assign rd_timeout = timeout_q;
`else
    assign rd_timeout = 1'b0;
`endif

    assign rd_busy    = busy_q;
    assign rd_done    = done_q;
    assign rd_data    = data_q;
    assign icap_csib  = csib_q;
    assign icap_rdwrb = rdwrb_q;
    assign icap_i     = icap_i_q;

endmodule

// File: tb/tb_icap_cfg_reader.sv
// Directed bench for icap_cfg_reader: header/desync words, latency, stalls, ignored requests, reset abort.
module tb_icap_cfg_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [4:0]  rd_reg_addr;
    logic        rd_busy, rd_done, rd_timeout;
    logic [31:0] rd_data;
    logic        icap_avail;
    logic        icap_csib, icap_rdwrb;
    logic [31:0] icap_i;
    logic [31:0] icap_o;

    always #5 clk = ~clk;

    icap_cfg_reader #(.READ_LAT(3), .AVAIL_TIMEOUT(20)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .rd_req      (rd_req),
        .rd_reg_addr (rd_reg_addr),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .rd_data     (rd_data),
        .rd_timeout  (rd_timeout),
        .icap_avail  (icap_avail),
        .icap_csib   (icap_csib),
        .icap_rdwrb  (icap_rdwrb),
        .icap_i      (icap_i),
        .icap_o      (icap_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wr_q[$];
    int          done_k, n_read, stall_viol, busy_bad, extra_done;
    logic        done_tmo, post_busy, post_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: rd_req in cycle 0, avail low for cycles 1..stall, optional extra rd_req in cycle extra_k.
    task automatic run_read(input logic [4:0] addr, input logic [31:0] raw, input int stall, input int extra_k);
        wr_q.delete();
        done_k = -1; n_read = 0; stall_viol = 0; busy_bad = 0; done_tmo = 1'b0;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_reg_addr = addr; icap_o = raw; icap_avail = (stall == 0);
        for (int k = 1; k < 2000 && done_k < 0; k++) begin
            @(posedge clk); #1;
            rd_req      = (k == extra_k);
            rd_reg_addr = 5'h1F;
            icap_avail  = (k >= stall + 1);
            @(negedge clk);
            if (rd_done) begin
                done_k   = k;
                done_tmo = rd_timeout;
            end else if (!rd_busy) begin
                busy_bad++;
            end
            if (!icap_csib && !icap_rdwrb) wr_q.push_back(icap_i);
            if (!icap_csib && icap_rdwrb) n_read++;
            if (k <= stall + 1 && !icap_csib) stall_viol++;
        end
        @(posedge clk); #1;
        rd_req = 1'b0; icap_avail = 1'b1;
        @(negedge clk);
        post_busy = rd_busy;
        post_done = rd_done;
    endtask

    task automatic check_seq(input string tag, input logic [31:0] hdr5);
        logic [31:0] exp_w[11];
        exp_w = '{32'hFFFFFFFF, 32'h5599AA66, 32'h04000000, 32'h04000000, hdr5,
                  32'h04000000, 32'h04000000,
                  32'h0C000180, 32'h000000B0, 32'h04000000, 32'h04000000};
        chk({tag, "_nwords"}, 32'(wr_q.size()), 32'd11);
        if (wr_q.size() == 11) begin
            for (int i = 0; i < 11; i++) chk($sformatf("%s_w%0d", tag, i), wr_q[i], exp_w[i]);
        end
    endtask

    task automatic idle_watch(input int cycles);
        extra_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rd_done || rd_busy || !icap_csib) extra_done++;
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_req = 1'b0; rd_reg_addr = 5'd0; icap_avail = 1'b1; icap_o = 32'h0;
        #23;
        chk("rst_csib", 32'(icap_csib), 32'd1);
        chk("rst_rdwrb", 32'(icap_rdwrb), 32'd0);
        chk("rst_icap_i", icap_i, 32'hFFFFFFFF);
        chk("rst_busy", 32'(rd_busy), 32'd0);
        chk("rst_done", 32'(rd_done), 32'd0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_timeout", 32'(rd_timeout), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // IDCODE: logical 04B51093 arrives on O as 20AD08C9
        run_read(5'h0C, 32'h20AD08C9, 0, -1);
        chk("id_latency", 32'(done_k), 32'd18);
        chk("id_data", rd_data, 32'h04B51093);
        chk("id_nread", 32'(n_read), 32'd3);
        chk("id_busy", 32'(busy_bad), 32'd0);
        chk("id_timeout", 32'(done_tmo), 32'd0);
        chk("id_post", {30'd0, post_busy, post_done}, 32'd0);
        check_seq("id", 32'h14800180);

        // BOOTSTS: low byte 01 mirrors to 80
        run_read(5'h16, 32'h00000001, 0, -1);
        chk("bs_latency", 32'(done_k), 32'd18);
        chk("bs_data", rd_data, 32'h00000080);
        check_seq("bs", 32'h14400380);

        // avail low for 10 cycles after the request
        run_read(5'h0C, 32'h20AD08C9, 10, -1);
        chk("stall_latency", 32'(done_k), 32'd28);
        chk("stall_csib", 32'(stall_viol), 32'd0);
        chk("stall_data", rd_data, 32'h04B51093);
        check_seq("stall", 32'h14800180);

        // second request during READ is dropped
        run_read(5'h16, 32'hFF000000, 0, 11);
        chk("busyreq_latency", 32'(done_k), 32'd18);
        chk("busyreq_data", rd_data, 32'hFF000000);
        chk("busyreq_post", {30'd0, post_busy, post_done}, 32'd0);
        idle_watch(25);
        chk("busyreq_no_second", 32'(extra_done), 32'd0);

        // request coinciding with DONE is dropped
        run_read(5'h0C, 32'h20AD08C9, 0, 18);
        chk("donereq_latency", 32'(done_k), 32'd18);
        chk("donereq_post", {30'd0, post_busy, post_done}, 32'd0);
        idle_watch(25);
        chk("donereq_no_second", 32'(extra_done), 32'd0);

        // a fresh request from idle is accepted
        run_read(5'h16, 32'h00000001, 0, -1);
        chk("after_latency", 32'(done_k), 32'd18);
        chk("after_data", rd_data, 32'h00000080);

`ifdef ICAP_RD_TIMEOUT_EN
        run_read(5'h0C, 32'h20AD08C9, 1000, -1);
        chk("tmo_latency", 32'(done_k), 32'd21);
        chk("tmo_flag", 32'(done_tmo), 32'd1);
        chk("tmo_csib", 32'(stall_viol), 32'd0);
        chk("tmo_nwords", 32'(wr_q.size()), 32'd0);
        chk("tmo_data", rd_data, 32'h00000080);
`endif

        // reset during READ aborts without desync
        @(posedge clk); #1;
        rd_req = 1'b1; rd_reg_addr = 5'h0C; icap_o = 32'h20AD08C9; icap_avail = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_in_read", {30'd0, icap_csib, icap_rdwrb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_csib", 32'(icap_csib), 32'd1);
        chk("mid_rst_rdwrb", 32'(icap_rdwrb), 32'd0);
        chk("mid_rst_icap_i", icap_i, 32'hFFFFFFFF);
        chk("mid_rst_busy", 32'(rd_busy), 32'd0);
        chk("mid_rst_data", rd_data, 32'h0);
        #20 rst_n = 1'b1;
        idle_watch(20);
        chk("rst_no_desync", 32'(extra_done), 32'd0);
        run_read(5'h0C, 32'h20AD08C9, 0, -1);
        chk("rst_rerun_latency", 32'(done_k), 32'd18);
        chk("rst_rerun_data", rd_data, 32'h04B51093);
        check_seq("rst_rerun", 32'h14800180);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
